count_tracker: RTL and testbench

- Observer/reader for the 4-bit up/down counter's output bus (Q, qcc).
- Samples the counter's Q and qcc every cp edge and infers count direction.
- Extends the 4-bit count to a (HI_W+4)-bit absolute count by tracking wraps.
- Flags illegal steps (load/clear jumps) and carry-flag inconsistencies, so a 4-bit counter can drive wide event counts without cascading.

---
 rtl/count_tracker.sv | 165 ++++++++++++++++
 tb/tb_count_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/count_tracker.sv
// count_tracker: watches a 4-bit up/down counter's Q/qcc bus and rebuilds a wide
// absolute count by following wraps, flagging illegal jumps and carry-flag mismatches.
module count_tracker #(
  parameter int unsigned HI_W = 12,
  parameter int unsigned ERRW = 4
) (
  input  logic              cp,
  input  logic              clr,
  input  logic [3:0]        q_in,
  input  logic              qcc_in,
  input  logic              track_en,
  input  logic              resync,
  output logic [HI_W+3:0]   ext_cnt,
  output logic              valid,
  output logic              dir,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic              jump,
  output logic              qcc_err,
  output logic [ERRW-1:0]   jump_cnt
);

  localparam logic [ERRW-1:0] JCNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_prev;
  logic [HI_W-1:0] r_hi;
  logic [3:0]      r_lo;
  logic            r_valid;
  logic            r_dir;
  logic            r_wrap_up;
  logic            r_wrap_dn;
  logic            r_jump;
  logic            r_qcc_err;
  logic [ERRW-1:0] r_jcnt;

  // Step classification against the previously sampled nibble
  logic [3:0]      w_d;
  logic            w_up;
  logic            w_dn;
  logic            w_jump;
  logic            w_wrap_up;
  logic            w_wrap_dn;
  logic            w_qcc_bad;
  logic [ERRW-1:0] w_jcnt_inc;

  assign w_d        = q_in - r_prev;
  assign w_up       = (w_d == 4'd1);
  assign w_dn       = (w_d == 4'hF);
  assign w_jump     = (w_d != 4'd0) && !w_up && !w_dn;
  assign w_wrap_up  = (r_prev == 4'hF) && (q_in == 4'd0);
  assign w_wrap_dn  = (r_prev == 4'd0) && (q_in == 4'hF);
  assign w_qcc_bad  = (w_up || w_dn) && (qcc_in != (w_wrap_up || w_wrap_dn));
  assign w_jcnt_inc = (r_jcnt == JCNT_MAX) ? r_jcnt : r_jcnt + ERRW'(1);

  always_ff @(posedge cp or negedge clr) begin
    if (!clr) begin
      r_state   <= S_IDLE;
      r_prev    <= 4'd0;
      r_hi      <= '0;
      r_lo      <= 4'd0;
      r_valid   <= 1'b0;
      r_dir     <= 1'b1;
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
      r_jump    <= 1'b0;
      r_qcc_err <= 1'b0;
      r_jcnt    <= '0;
    end else begin
      r_wrap_up <= 1'b0;
      r_wrap_dn <= 1'b0;
      r_jump    <= 1'b0;

      // Error bookkeeping clears on resync whether or not tracking is enabled
      if (resync) begin
        r_qcc_err <= 1'b0;
        r_jcnt    <= '0;
      end

      if (!track_en) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
      end else if (resync) begin
        r_prev  <= q_in;
        r_hi    <= '0;
        r_lo    <= q_in;
        r_state <= S_ACQ;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_prev  <= q_in;
            r_hi    <= '0;
            r_lo    <= q_in;
            r_state <= S_ACQ;
            r_valid <= 1'b0;
          end

          S_ACQ: begin
            r_prev <= q_in;
            r_lo   <= q_in;
            if (w_jump) begin
              r_hi   <= '0;
              r_jump <= 1'b1;
              r_jcnt <= w_jcnt_inc;
            end else begin
              r_state <= S_TRACK;
              r_valid <= 1'b1;
              if (w_up) r_dir <= 1'b1;
              if (w_dn) r_dir <= 1'b0;
            end
          end

          S_TRACK: begin
            r_prev <= q_in;
            if (w_jump) begin
              r_state <= S_ACQ;
              r_valid <= 1'b0;
              r_hi    <= '0;
              r_lo    <= q_in;
              r_jump  <= 1'b1;
              r_jcnt  <= w_jcnt_inc;
            end else if (w_up) begin
              r_dir <= 1'b1;
              r_lo  <= q_in;
              if (w_wrap_up) begin
                r_hi      <= r_hi + HI_W'(1);
                r_wrap_up <= 1'b1;
              end
            end else if (w_dn) begin
              r_dir <= 1'b0;
              r_lo  <= q_in;
              if (w_wrap_dn) begin
                r_hi      <= r_hi - HI_W'(1);
                r_wrap_dn <= 1'b1;
              end
            end
            if (w_qcc_bad) r_qcc_err <= 1'b1;
          end

          default: begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ext_cnt  = {r_hi, r_lo};
  assign valid    = r_valid;
  assign dir      = r_dir;
  assign wrap_up  = r_wrap_up;
  assign wrap_dn  = r_wrap_dn;
  assign jump     = r_jump;
  assign qcc_err  = r_qcc_err;
  assign jump_cnt = r_jcnt;

endmodule

// File: tb/tb_count_tracker.sv
// Bench for count_tracker: directed vector table, corner sequences, and random
// traffic checked against an absolute-count reference model.
module tb_count_tracker;

  localparam int unsigned HI_W    = 12;
  localparam int unsigned ERRW    = 4;
  localparam int          EXT_MOD = 1 << (HI_W + 4);
  localparam int          JMAX    = (1 << ERRW) - 1;

  logic              cp;
  logic              clr;
  logic [3:0]        q_in;
  logic              qcc_in;
  logic              track_en;
  logic              resync;
  logic [HI_W+3:0]   ext_cnt;
  logic              valid;
  logic              dir;
  logic              wrap_up;
  logic              wrap_dn;
  logic              jump;
  logic              qcc_err;
  logic [ERRW-1:0]   jump_cnt;

  count_tracker #(.HI_W(HI_W), .ERRW(ERRW)) dut (
    .cp(cp), .clr(clr), .q_in(q_in), .qcc_in(qcc_in), .track_en(track_en),
    .resync(resync), .ext_cnt(ext_cnt), .valid(valid), .dir(dir),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .jump(jump), .qcc_err(qcc_err),
    .jump_cnt(jump_cnt)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=acquiring 2=tracking; count kept as one integer
  int m_mode, m_prev, m_ext, m_jcnt;
  bit m_valid, m_dir, m_wu, m_wd, m_jmp, m_qerr;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_ext = 0; m_jcnt = 0;
    m_valid = 0; m_dir = 1; m_wu = 0; m_wd = 0; m_jmp = 0; m_qerr = 0;
  endtask

  task automatic model_step(input bit te, input bit rs, input int q, input bit qcc);
    int  d;
    bit  is_wu, is_wd;
    m_wu = 0; m_wd = 0; m_jmp = 0;
    if (rs) begin m_qerr = 0; m_jcnt = 0; end
    if (!te) begin
      m_mode = 0; m_valid = 0;
    end else if (rs || m_mode == 0) begin
      m_prev = q; m_ext = q; m_mode = 1; m_valid = 0;
    end else begin
      d     = (q - m_prev + 16) % 16;
      is_wu = (m_prev == 15) && (q == 0);
      is_wd = (m_prev == 0) && (q == 15);
      if (d != 0 && d != 1 && d != 15) begin
        m_jmp = 1;
        if (m_jcnt < JMAX) m_jcnt++;
        m_ext = q; m_mode = 1; m_valid = 0;
      end else if (m_mode == 1) begin
        m_mode = 2; m_valid = 1; m_ext = q;
        if (d == 1)  m_dir = 1;
        if (d == 15) m_dir = 0;
      end else begin
        if (d == 1)  begin m_dir = 1; m_ext = (m_ext + 1) % EXT_MOD; m_wu = is_wu; end
        if (d == 15) begin m_dir = 0; m_ext = (m_ext + EXT_MOD - 1) % EXT_MOD; m_wd = is_wd; end
        if (d != 0 && (qcc != (is_wu || is_wd))) m_qerr = 1;
      end
      m_prev = q;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ext"},   32'(ext_cnt),  32'(m_ext));
    chk({tag, ".valid"}, 32'(valid),    32'(m_valid));
    chk({tag, ".dir"},   32'(dir),      32'(m_dir));
    chk({tag, ".wu"},    32'(wrap_up),  32'(m_wu));
    chk({tag, ".wd"},    32'(wrap_dn),  32'(m_wd));
    chk({tag, ".jmp"},   32'(jump),     32'(m_jmp));
    chk({tag, ".qerr"},  32'(qcc_err),  32'(m_qerr));
    chk({tag, ".jcnt"},  32'(jump_cnt), 32'(m_jcnt));
  endtask

  int cur_q = 0;

  // Drive one sample, let the edge happen, then compare outputs with the model
  task automatic step(input bit te, input bit rs, input int q, input bit qcc, input string tag);
    track_en = te; resync = rs; q_in = 4'(q); qcc_in = qcc;
    cur_q = q;
    @(posedge cp);
    model_step(te, rs, q, qcc);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit te; bit rs; int q; bit qcc;
    int ext; bit vld; bit dr; bit wu; bit wd; bit jp; bit qe; int jc;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1,0, 2,0, 'h0002,0,1,0,0,0,0,0};
    tbl[1]  = '{1,0, 3,0, 'h0003,1,1,0,0,0,0,0};
    tbl[2]  = '{1,1,14,0, 'h000E,0,1,0,0,0,0,0};
    tbl[3]  = '{1,0,14,0, 'h000E,1,1,0,0,0,0,0};
    tbl[4]  = '{1,0,15,0, 'h000F,1,1,0,0,0,0,0};
    tbl[5]  = '{1,0, 0,1, 'h0010,1,1,1,0,0,0,0};
    tbl[6]  = '{1,0, 1,0, 'h0011,1,1,0,0,0,0,0};
    tbl[7]  = '{1,0, 0,0, 'h0010,1,0,0,0,0,0,0};
    tbl[8]  = '{1,0,15,1, 'h000F,1,0,0,1,0,0,0};
    tbl[9]  = '{1,0,15,0, 'h000F,1,0,0,0,0,0,0};
    tbl[10] = '{1,0, 0,0, 'h0010,1,1,1,0,0,1,0};
    tbl[11] = '{1,0, 1,0, 'h0011,1,1,0,0,0,1,0};
    tbl[12] = '{1,1, 1,0, 'h0001,0,1,0,0,0,0,0};
    tbl[13] = '{1,0, 1,0, 'h0001,1,1,0,0,0,0,0};
    tbl[14] = '{1,0, 5,0, 'h0005,0,1,0,0,1,0,1};
    tbl[15] = '{1,0, 6,0, 'h0006,1,1,0,0,0,0,1};
    tbl[16] = '{1,0, 9,0, 'h0009,0,1,0,0,1,0,2};
    tbl[17] = '{1,0,10,0, 'h000A,1,1,0,0,0,0,2};
    tbl[18] = '{0,0, 3,0, 'h000A,0,1,0,0,0,0,2};
    tbl[19] = '{0,1, 3,0, 'h000A,0,1,0,0,0,0,0};
    tbl[20] = '{1,0, 7,0, 'h0007,0,1,0,0,0,0,0};

    clr = 1'b0; track_en = 1'b0; resync = 1'b0; q_in = 4'd0; qcc_in = 1'b0;
    model_reset();
    #12;
    chk("rst.ext",   32'(ext_cnt),  32'h0);
    chk("rst.valid", 32'(valid),    32'h0);
    chk("rst.dir",   32'(dir),      32'h1);
    chk("rst.jcnt",  32'(jump_cnt), 32'h0);
    clr = 1'b1;

    for (int i = 0; i < 21; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(tbl[i].te, tbl[i].rs, tbl[i].q, tbl[i].qcc, t);
      chk({t, ".ext_tbl"},   32'(ext_cnt),  32'(tbl[i].ext));
      chk({t, ".valid_tbl"}, 32'(valid),    32'(tbl[i].vld));
      chk({t, ".dir_tbl"},   32'(dir),      32'(tbl[i].dr));
      chk({t, ".pulse_tbl"}, {29'd0, wrap_up, wrap_dn, jump},
          {29'd0, tbl[i].wu, tbl[i].wd, tbl[i].jp});
      chk({t, ".qerr_tbl"},  32'(qcc_err),  32'(tbl[i].qe));
      chk({t, ".jcnt_tbl"},  32'(jump_cnt), 32'(tbl[i].jc));
    end

    // 17 consecutive jumps in acquisition: counter must stop at its maximum
    for (int i = 0; i < 17; i++) step(1, 0, (i % 2 == 0) ? 15 : 7, 0, "sat");
    chk("sat.jcnt", 32'(jump_cnt), 32'(JMAX));
    chk("sat.jump", 32'(jump), 32'h1);

    // Upper field wraps silently in both directions
    step(1, 1, 0, 0, "hw.rs");
    step(1, 0, 0, 0, "hw.acq");
    step(1, 0, 15, 1, "hw.dn");
    chk("hw.ext_ffff", 32'(ext_cnt), 32'hFFFF);
    chk("hw.wd", 32'(wrap_dn), 32'h1);
    step(1, 0, 0, 1, "hw.up");
    chk("hw.ext_0", 32'(ext_cnt), 32'h0000);
    chk("hw.wu", 32'(wrap_up), 32'h1);

    // Count up to 0x123, then pull clr between edges
    for (int i = 1; i <= 'h123; i++) step(1, 0, i % 16, (i % 16) == 0, "cnt");
    chk("cnt.ext_123", 32'(ext_cnt), 32'h0123);
    #2 clr = 1'b0;
    #1;
    chk("arst.ext",   32'(ext_cnt),  32'h0);
    chk("arst.valid", 32'(valid),    32'h0);
    chk("arst.dir",   32'(dir),      32'h1);
    chk("arst.pulse", {29'd0, wrap_up, wrap_dn, jump}, 32'h0);
    chk("arst.qerr",  32'(qcc_err),  32'h0);
    model_reset();
    #3 clr = 1'b1;

    // HOLD for five samples after a down step: nothing moves
    step(1, 0, 4, 0, "hold.acq");
    step(1, 0, 3, 0, "hold.dn");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 3, 0, "hold");
      chk("hold.ext", 32'(ext_cnt), 32'h0003);
      chk("hold.dir", 32'(dir), 32'h0);
    end

    // Random traffic mostly shaped like a real counter, with occasional faults
    for (int n = 0; n < 3000; n++) begin
      int  r, q;
      bit  te, rs, qcc;
      te = ($urandom_range(0, 99) < 96);
      rs = ($urandom_range(0, 99) < 3);
      r  = $urandom_range(0, 99);
      if (r < 30)      q = cur_q;
      else if (r < 65) q = (cur_q + 1) % 16;
      else if (r < 95) q = (cur_q + 15) % 16;
      else             q = $urandom_range(0, 15);
      qcc = ((cur_q == 15) && (q == 0)) || ((cur_q == 0) && (q == 15));
      if ($urandom_range(0, 99) < 3) qcc = !qcc;
      step(te, rs, q, qcc, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
